// File: rtl/fir_mac_seq.sv
// Sequencer for a serial symmetric FIR: one pre-adder, one MAC.
// Steps tap-pair addresses and pipelines accumulator control.
module fir_mac_seq #(
  parameter int NTAP = 31,
  parameter int AW   = 5,
  parameter int CW   = 4,
  parameter int PIPE = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          f_s,
  input  logic          ovr_clr,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [AW-1:0] rd_addr_a,
  output logic [AW-1:0] rd_addr_b,
  output logic [CW-1:0] coef_addr,
  output logic          mid,
  output logic          mac_clr,
  output logic          mac_en,
  output logic          dout_ld,
  output logic          busy,
  output logic          ovr
);

  localparam int H = (NTAP + 1) / 2;
  localparam bit ODD = (NTAP % 2) == 1;
  localparam logic [CW-1:0] KLAST = CW'(H - 1);
  localparam logic [AW-1:0] NM1 = AW'(NTAP - 1);
  localparam logic [2:0] DLAST =
    3'((PIPE > 0) ? PIPE - 1 : 0);

  typedef enum logic [2:0] {
    IDLE, WR, RUN, DRAIN, DONE
  } st_t;

  st_t st_q, st_d;
  logic [CW-1:0] k_q, k_d;
  logic [2:0] d_q, d_d;
  logic [AW-1:0] wptr_q;
  logic pl0, pl1, go;
  logic en_raw, clr_raw, run;
  logic [AW-1:0] a_run, b_run;
  logic [AW-1:0] a_hold, b_hold;
  logic [CW-1:0] c_hold;

  assign go = pl0 & ~pl1;
  assign run = (st_q == RUN);
  assign busy = (st_q != IDLE);
  assign wr_addr = wptr_q;

  // b walks up from the oldest sample while a walks down
  assign a_run = wptr_q - AW'(k_q);
  assign b_run = wptr_q - NM1 + AW'(k_q);

  assign rd_addr_a = run ? a_run : a_hold;
  assign rd_addr_b = run ? b_run : b_hold;
  assign coef_addr = run ? k_q : c_hold;

  always_ff @(posedge clk) begin
    if (!rst) begin
      st_q   <= IDLE;
      k_q    <= '0;
      d_q    <= '0;
      wptr_q <= '0;
      pl0    <= 1'b0;
      pl1    <= 1'b0;
      a_hold <= '0;
      b_hold <= '0;
      c_hold <= '0;
      ovr    <= 1'b0;
    end else begin
      st_q <= st_d;
      k_q  <= k_d;
      d_q  <= d_d;
      pl0  <= f_s;
      pl1  <= pl0;
      if (st_q == DONE)
        wptr_q <= wptr_q + 1'b1;
      if (run) begin
        a_hold <= a_run;
        b_hold <= b_run;
        c_hold <= k_q;
      end
      if (go && busy)
        ovr <= 1'b1;
      else if (ovr_clr)
        ovr <= 1'b0;
    end
  end

  always_comb begin
    st_d    = st_q;
    k_d     = k_q;
    d_d     = d_q;
    wr_en   = 1'b0;
    en_raw  = 1'b0;
    clr_raw = 1'b0;
    mid     = 1'b0;
    dout_ld = 1'b0;
    unique case (st_q)
      IDLE: begin
        if (go)
          st_d = WR;
      end
      WR: begin
        wr_en = 1'b1;
        k_d   = '0;
        st_d  = RUN;
      end
      RUN: begin
        en_raw  = 1'b1;
        clr_raw = (k_q == '0);
        mid     = ODD && (k_q == KLAST);
        if (k_q == KLAST) begin
          d_d  = '0;
          st_d = (PIPE == 0) ? DONE : DRAIN;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      DRAIN: begin
        if (d_q == DLAST)
          st_d = DONE;
        else
          d_d = d_q + 1'b1;
      end
      DONE: begin
        dout_ld = 1'b1;
        st_d    = IDLE;
      end
      default: st_d = IDLE;
    endcase
  end

  if (PIPE == 0) begin : g_nopipe
    assign mac_en  = en_raw;
    assign mac_clr = clr_raw;
  end else begin : g_pipe
    logic [PIPE-1:0] en_p, clr_p;
    always_ff @(posedge clk) begin
      if (!rst) begin
        en_p  <= '0;
        clr_p <= '0;
      end else begin
        en_p  <= (en_p << 1) | PIPE'(en_raw);
        clr_p <= (clr_p << 1) | PIPE'(clr_raw);
      end
    end
    assign mac_en  = en_p[PIPE-1];
    assign mac_clr = clr_p[PIPE-1];
  end

endmodule
